// File: rtl/temp_mon_pkg.sv
// rtl/temp_mon_pkg.sv - shared widths, thresholds and state type for the temperature monitor chain
package temp_mon_pkg;

  localparam int SUM_W  = 16;
  localparam int CNT_W  = 8;
  localparam int TEMP_W = 8;
  localparam int ITER_W = 5;

  localparam logic [TEMP_W-1:0] LOW_TH_DEF  = 8'd19;
  localparam logic [TEMP_W-1:0] HIGH_TH_DEF = 8'd26;

  localparam logic [ITER_W-1:0] LAST_ITER = 5'd15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  typedef struct packed {
    logic [TEMP_W-1:0] avg;
    logic [TEMP_W-1:0] rem;
    logic              div_zero;
    logic              cold;
    logic              heat;
  } result_t;

  function automatic logic saturates(input logic [SUM_W-1:0] quot);
    return quot[SUM_W-1:TEMP_W] != '0;
  endfunction

  function automatic logic [TEMP_W-1:0] sat_quot(input logic [SUM_W-1:0] quot);
    return saturates(quot) ? {TEMP_W{1'b1}} : quot[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/seq_divider_16x8.sv
// rtl/seq_divider_16x8.sv - 16-step restoring divider, 16-bit dividend by 8-bit divisor
module seq_divider_16x8
  import temp_mon_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SUM_W-1:0] quot_o,
  output logic [CNT_W-1:0] rem_o
);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]  quot_q, quot_d;
  logic [CNT_W:0]    prem_q, prem_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W:0]    shifted;
  logic [CNT_W:0]    diff;
  logic              fits;

  always_comb begin
    shifted = {prem_q[CNT_W-1:0], quot_q[SUM_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = shifted >= {1'b0, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = '0;
          quot_d  = dividend_i;
          prem_d  = '0;
          dvs_d   = divisor_i;
        end
      end
      CALC: begin
        // quotient bits enter from the LSB as dividend bits leave the MSB
        quot_d = {quot_q[SUM_W-2:0], fits};
        prem_d = fits ? diff : shifted;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
    end
  end

  // done_o flags the final step; quot_o/rem_o are that step's result so the
  // parent can register it on the same edge the divider returns to IDLE
  assign busy_o = (state_q == CALC);
  assign done_o = (state_q == CALC) && (cnt_q == LAST_ITER);
  assign quot_o = quot_d;
  assign rem_o  = prem_d[CNT_W-1:0];

endmodule

// File: rtl/temp_average_seq.sv
// rtl/temp_average_seq.sv - averaging stage: sum / active count with saturation and cold/heat alerts
module temp_average_seq
  import temp_mon_pkg::*;
#(
  parameter logic [TEMP_W-1:0] LOW_TH  = LOW_TH_DEF,
  parameter logic [TEMP_W-1:0] HIGH_TH = HIGH_TH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [SUM_W-1:0]  temp_sum_i,
  input  logic [CNT_W-1:0]  nr_active_sensors_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [TEMP_W-1:0] avg_o,
  output logic [TEMP_W-1:0] rem_o,
  output logic              div_zero_o,
  output logic              cold_o,
  output logic              heat_o
);

  logic              div_busy;
  logic              div_done;
  logic              div_start;
  logic              zero_req;
  logic [SUM_W-1:0]  div_quot;
  logic [CNT_W-1:0]  div_rem;
  logic [TEMP_W-1:0] avg_sat;
  result_t           res_q, res_d;
  logic              done_q, done_d;

  assign zero_req  = start_i && !div_busy && (nr_active_sensors_i == '0);
  assign div_start = start_i && (nr_active_sensors_i != '0);

  seq_divider_16x8 u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (div_start),
    .dividend_i (temp_sum_i),
    .divisor_i  (nr_active_sensors_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    res_d   = res_q;
    done_d  = 1'b0;
    avg_sat = sat_quot(div_quot);
    if (zero_req) begin
      res_d          = '0;
      res_d.div_zero = 1'b1;
      done_d         = 1'b1;
    end else if (div_done) begin
      // alerts follow the clipped average, not the raw quotient
      res_d.avg      = avg_sat;
      res_d.rem      = saturates(div_quot) ? '0 : div_rem;
      res_d.div_zero = 1'b0;
      res_d.cold     = avg_sat < LOW_TH;
      res_d.heat     = avg_sat > HIGH_TH;
      done_d         = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = div_busy;
  assign done_o     = done_q;
  assign avg_o      = res_q.avg;
  assign rem_o      = res_q.rem;
  assign div_zero_o = res_q.div_zero;
  assign cold_o     = res_q.cold;
  assign heat_o     = res_q.heat;

endmodule

// File: tb/tb_temp_average_seq.sv
// tb/tb_temp_average_seq.sv - scoreboard bench for temp_average_seq with randomized requests
module tb_temp_average_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] temp_sum_i;
  logic [7:0]  nr_active_sensors_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  avg_o;
  logic [7:0]  rem_o;
  logic        div_zero_o;
  logic        cold_o;
  logic        heat_o;

  temp_average_seq dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .temp_sum_i          (temp_sum_i),
    .nr_active_sensors_i (nr_active_sensors_i),
    .start_i             (start_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .avg_o               (avg_o),
    .rem_o               (rem_o),
    .div_zero_o          (div_zero_o),
    .cold_o              (cold_o),
    .heat_o              (heat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int avg;
    int rem;
    int dz;
    int cold;
    int heat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  bit   busy_exp[int];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int s, input int n, input int e0);
    exp_t r;
    int   q;
    if (n == 0) begin
      r.avg = 0; r.rem = 0; r.dz = 1; r.cold = 0; r.heat = 0;
      r.cyc = e0;
    end else begin
      q = s / n;
      if (q > 255) begin
        r.avg = 255; r.rem = 0;
      end else begin
        r.avg = q; r.rem = s % n;
      end
      r.dz   = 0;
      r.cold = (r.avg < 19) ? 1 : 0;
      r.heat = (r.avg > 26) ? 1 : 0;
      r.cyc  = e0 + 16;
    end
    return r;
  endfunction

  // monitor: busy window every cycle, result fields whenever done_o shows
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", 32'(busy_o), 32'(busy_exp.exists(cyc)));
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("avg", 32'(avg_o), 32'(e.avg));
          chk("rem", 32'(rem_o), 32'(e.rem));
          chk("div_zero", 32'(div_zero_o), 32'(e.dz));
          chk("cold", 32'(cold_o), 32'(e.cold));
          chk("heat", 32'(heat_o), 32'(e.heat));
        end
      end
    end
  end

  task automatic issue(input int s, input int n);
    int e0;
    e0 = cyc + 1;
    temp_sum_i          = 16'(s);
    nr_active_sensors_i = 8'(n);
    start_i             = 1'b1;
    sb.push_back(model(s, n, e0));
    if (n != 0) for (int k = 0; k < 16; k++) busy_exp[e0 + k] = 1'b1;
  endtask

  task automatic wait_empty(input int bound);
    int t;
    t = 0;
    while (sb.size() != 0 && t < bound) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic single(input int s, input int n);
    issue(s, n);
    @(negedge clk_i);
    start_i = 1'b0;
    wait_empty(40);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_avg"}, 32'(avg_o), 32'd0);
    chk({tag, "_rem"}, 32'(rem_o), 32'd0);
    chk({tag, "_div_zero"}, 32'(div_zero_o), 32'd0);
    chk({tag, "_cold"}, 32'(cold_o), 32'd0);
    chk({tag, "_heat"}, 32'(heat_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int s, n, sel;

    // reset with a zero-divisor start present: must be ignored
    rst_n_i             = 1'b0;
    start_i             = 1'b1;
    temp_sum_i          = 16'd500;
    nr_active_sensors_i = 8'd0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_done", 32'(done_o), 32'd0);
    mon_en = 1'b1;

    single(1000, 40);
    single(100, 3);
    single(500, 0);
    single(60000, 1);
    single(76, 4);
    single(0, 7);

    // consecutive zero-divisor requests pulse done every cycle
    issue(500, 0);
    @(negedge clk_i);
    issue(300, 0);
    @(negedge clk_i);
    start_i = 1'b0;
    wait_empty(10);

    // held start; inputs change mid-computation and are picked up only at E17
    issue(76, 4);
    e0 = cyc + 1;
    while (cyc < e0 + 4) @(negedge clk_i);
    temp_sum_i          = 16'd10;
    nr_active_sensors_i = 8'd1;
    sb.push_back(model(10, 1, e0 + 17));
    for (int k = 0; k < 16; k++) busy_exp[e0 + 17 + k] = 1'b1;
    while (cyc < e0 + 17) @(negedge clk_i);
    start_i = 1'b0;
    wait_empty(60);

    // reset at E8 of a running division: no done, everything cleared
    e0 = cyc + 1;
    temp_sum_i          = 16'd1000;
    nr_active_sensors_i = 8'd40;
    start_i             = 1'b1;
    for (int k = 0; k < 8; k++) busy_exp[e0 + k] = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (cyc < e0 + 7) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    #1;
    check_all_zero("mid_reset");
    rst_n_i = 1'b1;
    repeat (20) @(negedge clk_i);
    single(1000, 40);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      s   = $urandom_range(0, 65535);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = $urandom_range(1, 4);
      else if (sel == 2) begin
        n = $urandom_range(1, 40);
        s = $urandom_range(0, 40 * n);
      end else           n = $urandom_range(1, 255);
      single(s, n);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (5) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_average_seq.md
# temp_average_seq

Sequential averaging stage placed directly downstream of the sensor aggregation stage. It takes the 16-bit temperature sum and the 8-bit active-sensor count, computes the integer mean with a 16-iteration restoring divider, and raises cold/heat alert flags against fixed thresholds. Results are registered and held until the next completed computation.

## Interface
- `LOW_TH`, default 19: cold threshold. `cold_o` is set when avg < LOW_TH.
- `HIGH_TH`, default 26: heat threshold. `heat_o` is set when avg > HIGH_TH.
- `clk_i` in 1: single clock. All state changes on the rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `temp_sum_i` in 16: sum of temperatures from active sensors.
- `nr_active_sensors_i` in 8: divisor (number of active sensors).
- `start_i` in 1: request. Sampled only in IDLE.
- `busy_o` out 1: high while a division is in progress.
- `done_o` out 1: one-cycle completion pulse.
- `avg_o` out 8: quotient, saturated to 255.
- `rem_o` out 8: remainder, valid when not saturated.
- `div_zero_o` out 1: last request had divisor 0.
- `cold_o` out 1: cold alert for the last result.
- `heat_o` out 1: heat alert for the last result.

## Operation
- **States:** IDLE and CALC. There is also a 5-bit iteration counter.
- **IDLE with `start_i`=1 at edge E0:**
  - Latch both operands.
  - If the divisor is nonzero: go to CALC, clear the counter, and set `busy_o`=1.
  - If the divisor is 0: stay in IDLE and update the outputs at E0: `avg_o`=0, `rem_o`=0, `div_zero_o`=1, `cold_o`=`heat_o`=0, `done_o`=1. `busy_o` never rises.
- **CALC:** performs one restoring step per edge, MSB first. The partial remainder is 9 bits and the quotient register is 16 bits.
- **Completion at E16:**
  - Return to IDLE.
  - `busy_o`=0 and `done_o`=1.
  - `avg_o` = quotient if quotient ≤ 255, else 255. When saturated, `rem_o`=0.
  - `rem_o` otherwise holds the final remainder.
  - `div_zero_o`=0.
  - `cold_o` and `heat_o` are computed from the saturated `avg_o`.
- **Truncating division.** No rounding.
- **Inputs during CALC are ignored.** Only the operands latched at E0 are used. `start_i` is ignored while `busy_o`=1.
- **Output hold:** `avg_o`, `rem_o`, `div_zero_o`, `cold_o`, `heat_o` hold their values until the next completion.
- **Reset (`rst_n_i`=0 at any edge):**
  - State goes to IDLE and the counter is cleared.
  - All outputs go to 0, including mid-CALC. A partial result is discarded and no `done_o` pulse is produced.
  - `start_i` is ignored on the reset edge.

## Timing
- **Reset values:** `busy_o`, `done_o`, `avg_o`, `rem_o`, `div_zero_o`, `cold_o`, `heat_o` are all 0.
- **Nonzero divisor:**
  - `busy_o` is high in the cycles after E0 through E15 (16 cycles).
  - `done_o` is high in the single cycle after E16.
  - Results become visible in that same cycle.
- **Zero divisor:** `done_o` is high in the cycle after E0. Latency is 1.
- **Back-to-back requests:** `start_i` high at E17 is accepted, because the block is in IDLE after E16. The throughput period is 17 cycles when `start_i` is held high.
- **Pulse width:** `done_o` is never high for two consecutive cycles, except for repeated zero-divisor requests, which may pulse every cycle.
- **Output path:** all outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `temp_mon_pkg`:**
  - Width constants: SUM_W=16, CNT_W=8, TEMP_W=8.
  - Default thresholds: 19 and 26.
  - State enum: IDLE, CALC.
  - Shared with the aggregation stage and the display stage.
- **Sub-module `seq_divider_16x8`:**
  - Restoring-division datapath and counter, with a start/done interface.
  - The top level adds the zero check, saturation, threshold compare, and output registers.

## Test plan
- **Exact average:** sum=1000, n=40, start at E0 → `busy_o` for 16 cycles, `done_o` after E16, `avg_o`=25, `rem_o`=0, `cold_o`=`heat_o`=0.
- **Remainder and heat:** sum=100, n=3 → `avg_o`=33, `rem_o`=1, `heat_o`=1, `cold_o`=0.
- **Zero divisor:** sum=500, n=0 → `done_o` in the cycle after E0, `busy_o` stays 0, `div_zero_o`=1, `avg_o`=0, alerts 0.
- **Held start and ignored inputs:**
  - `start_i` held high with sum=76, n=4.
  - At E5, change the inputs to sum=10, n=1.
  - Required: first result `avg_o`=19 with `cold_o`=0 (boundary case), `done_o` after E16.
  - Required: the next result, started at E17, gives `avg_o`=10 and `cold_o`=1, with `done_o` after E33.
- **Saturation:** sum=60000, n=1 → `avg_o`=255, `rem_o`=0, `heat_o`=1.
- **Reset mid-operation:** `rst_n_i`=0 at E8 of a sum=1000, n=40 run → next cycle has `busy_o`=0 and all outputs 0, with no `done_o` pulse. A later start gives `avg_o`=25 on schedule.
